// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//
// Fetch-stage sequencer sitting between the I-cache, the branch predictor and
// the instruction fetch buffer. It owns the fetch PC and keeps one I-cache
// request outstanding at a time. Each returned instruction is pushed into the
// fetch buffer together with its PC, its next-PC (predicted target or
// sequential PC) and the prediction bit. When the buffer is full the response
// is parked in hold registers. A flush redirects the PC. If a request is
// still in flight when the flush arrives, its response is squashed.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_en_i          branch-mispredict flush
//   flush_target_PC_i   redirect PC, valid with flush_en_i
//   icache_req_o        I-cache request valid
//   icache_addr_o       I-cache request address
//   icache_valid_i      response for the current request
//   icache_insn_i       response instruction
//   fetch_PC_o          current fetch PC, to the branch predictor
//   bp_pred_taken_i     prediction for fetch_PC_o
//   bp_target_PC_i      predicted target for fetch_PC_o
//   ifb_full_i          fetch buffer full
//   ifb_en_o            push into the fetch buffer
//   ifb_insn_o          pushed instruction
//   ifb_PC_o            pushed PC
//   ifb_target_PC_o     pushed next-PC
//   ifb_pred_bit_o      pushed prediction bit
//   fetch_state_o       FSM state (debug only)
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] INSN_BYTES = 64'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_en_i,
  input  logic [63:0] flush_target_PC_i,
  output logic        icache_req_o,
  output logic [63:0] icache_addr_o,
  input  logic        icache_valid_i,
  input  logic [31:0] icache_insn_i,
  output logic [63:0] fetch_PC_o,
  input  logic        bp_pred_taken_i,
  input  logic [63:0] bp_target_PC_i,
  input  logic        ifb_full_i,
  output logic        ifb_en_o,
  output logic [31:0] ifb_insn_o,
  output logic [63:0] ifb_PC_o,
  output logic [63:0] ifb_target_PC_o,
  output logic        ifb_pred_bit_o,
  output logic [1:0]  fetch_state_o
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] squash_pc_q, squash_pc_d;
  logic [31:0] hold_insn_q, hold_insn_d;
  logic [63:0] hold_pc_q, hold_pc_d;
  logic [63:0] hold_tgt_q, hold_tgt_d;
  logic        hold_pred_q, hold_pred_d;

  logic [63:0] nxt_pc;
  logic        push;

  // The next PC wraps modulo 2^64.
  assign nxt_pc = bp_pred_taken_i ? bp_target_PC_i : (pc_q + INSN_BYTES);

  // The reset cycle must not issue a request or push, whatever the state.
  assign icache_req_o  = ~rst & (state_q != HOLD);
  assign icache_addr_o = (state_q == SQUASH) ? squash_pc_q : pc_q;
  assign fetch_PC_o    = pc_q;
  assign fetch_state_o = state_q;
  assign ifb_en_o      = push & ~rst;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    squash_pc_d     = squash_pc_q;
    hold_insn_d     = hold_insn_q;
    hold_pc_d       = hold_pc_q;
    hold_tgt_d      = hold_tgt_q;
    hold_pred_d     = hold_pred_q;
    push            = 1'b0;
    ifb_insn_o      = icache_insn_i;
    ifb_PC_o        = pc_q;
    ifb_target_PC_o = nxt_pc;
    ifb_pred_bit_o  = bp_pred_taken_i;

    // A flush redirects the PC and discards any parked instruction in every state.
    if (flush_en_i) begin
      pc_d        = flush_target_PC_i;
      hold_insn_d = '0;
      hold_pc_d   = '0;
      hold_tgt_d  = '0;
      hold_pred_d = 1'b0;
    end

    case (state_q)
      FETCH: begin
        if (flush_en_i) begin
          // The old request is still outstanding. Keep presenting its address
          // until its response arrives, then drop that response.
          if (!icache_valid_i) begin
            squash_pc_d = pc_q;
            state_d     = SQUASH;
          end
        end else if (icache_valid_i) begin
          pc_d = nxt_pc;
          if (!ifb_full_i) begin
            push = 1'b1;
          end else begin
            hold_insn_d = icache_insn_i;
            hold_pc_d   = pc_q;
            hold_tgt_d  = nxt_pc;
            hold_pred_d = bp_pred_taken_i;
            state_d     = HOLD;
          end
        end
      end

      HOLD: begin
        ifb_insn_o      = hold_insn_q;
        ifb_PC_o        = hold_pc_q;
        ifb_target_PC_o = hold_tgt_q;
        ifb_pred_bit_o  = hold_pred_q;
        if (flush_en_i) begin
          state_d = FETCH;
        end else if (!ifb_full_i) begin
          push    = 1'b1;
          state_d = FETCH;
        end
      end

      SQUASH: begin
        if (icache_valid_i) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      squash_pc_q <= '0;
      hold_insn_q <= '0;
      hold_pc_q   <= '0;
      hold_tgt_q  <= '0;
      hold_pred_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      squash_pc_q <= squash_pc_d;
      hold_insn_q <= hold_insn_d;
      hold_pc_q   <= hold_pc_d;
      hold_tgt_q  <= hold_tgt_d;
      hold_pred_q <= hold_pred_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
//
// Directed bench for if_fetch_ctrl. Inputs change 1 ns after the rising edge.
// Outputs are sampled on the falling edge. A second instance with
// RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC shares the inputs and covers PC wrap.
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_en;
  logic [63:0] flush_tgt;
  logic        ic_valid;
  logic [31:0] ic_insn;
  logic        bp_taken;
  logic [63:0] bp_tgt;
  logic        ifb_full;

  logic        req_a, en_a, pred_a;
  logic [63:0] addr_a, fpc_a, ipc_a, itgt_a;
  logic [31:0] insn_a;
  logic [1:0]  st_a;

  logic        req_b, en_b, pred_b;
  logic [63:0] addr_b, fpc_b, ipc_b, itgt_b;
  logic [31:0] insn_b;
  logic [1:0]  st_b;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl dutA (
    .clk(clk), .rst(rst),
    .flush_en_i(flush_en), .flush_target_PC_i(flush_tgt),
    .icache_req_o(req_a), .icache_addr_o(addr_a),
    .icache_valid_i(ic_valid), .icache_insn_i(ic_insn),
    .fetch_PC_o(fpc_a),
    .bp_pred_taken_i(bp_taken), .bp_target_PC_i(bp_tgt),
    .ifb_full_i(ifb_full),
    .ifb_en_o(en_a), .ifb_insn_o(insn_a), .ifb_PC_o(ipc_a),
    .ifb_target_PC_o(itgt_a), .ifb_pred_bit_o(pred_a),
    .fetch_state_o(st_a)
  );

  if_fetch_ctrl #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dutB (
    .clk(clk), .rst(rst),
    .flush_en_i(flush_en), .flush_target_PC_i(flush_tgt),
    .icache_req_o(req_b), .icache_addr_o(addr_b),
    .icache_valid_i(ic_valid), .icache_insn_i(ic_insn),
    .fetch_PC_o(fpc_b),
    .bp_pred_taken_i(bp_taken), .bp_target_PC_i(bp_tgt),
    .ifb_full_i(ifb_full),
    .ifb_en_o(en_b), .ifb_insn_o(insn_b), .ifb_PC_o(ipc_b),
    .ifb_target_PC_o(itgt_b), .ifb_pred_bit_o(pred_b),
    .fetch_state_o(st_b)
  );

  // Advance to the falling edge, where outputs are sampled.
  task automatic sampleEdge();
    @(negedge clk);
  endtask

  // Advance past the next rising edge, where new inputs are driven.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reset both instances, then check the reset-cycle outputs and the first
  // post-reset request.
  task automatic test_reset();
    rst = 1'b1; flush_en = 1'b0; flush_tgt = '0; ic_valid = 1'b1;
    ic_insn = 32'hDEAD_0000; bp_taken = 1'b0; bp_tgt = '0; ifb_full = 1'b0;
    nextCycle();
    sampleEdge();
    nChecks++; if (req_a !== 1'b0) begin nFails++; $display("[TB] FAIL reset_req actual=%0b required=0", req_a); end
    nChecks++; if (en_a !== 1'b0) begin nFails++; $display("[TB] FAIL reset_en actual=%0b required=0", en_a); end
    nChecks++; if (st_a !== 2'd0) begin nFails++; $display("[TB] FAIL reset_state actual=%0d required=0", st_a); end
    nChecks++; if (fpc_a !== 64'h0) begin nFails++; $display("[TB] FAIL reset_pc actual=%h required=0", fpc_a); end
    nextCycle();
    rst = 1'b0; ic_valid = 1'b0;
    sampleEdge();
    nChecks++; if (req_a !== 1'b1) begin nFails++; $display("[TB] FAIL post_reset_req actual=%0b required=1", req_a); end
    nChecks++; if (addr_a !== 64'h0) begin nFails++; $display("[TB] FAIL post_reset_addr actual=%h required=0", addr_a); end
    nChecks++; if (en_a !== 1'b0) begin nFails++; $display("[TB] FAIL idle_no_push actual=%0b required=0", en_a); end
    nextCycle();
  endtask

  // Push PCs 0,4,8,C with a valid response on every cycle.
  task automatic test_sequential();
    ic_valid = 1'b1; bp_taken = 1'b0; ifb_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ic_insn = 32'h1000_0000 + i;
      sampleEdge();
      nChecks++; if (addr_a !== 64'(4 * i)) begin nFails++; $display("[TB] FAIL seq_addr[%0d] actual=%h required=%h", i, addr_a, 4 * i); end
      nChecks++; if (en_a !== 1'b1) begin nFails++; $display("[TB] FAIL seq_en[%0d] actual=%0b required=1", i, en_a); end
      nChecks++; if (ipc_a !== 64'(4 * i)) begin nFails++; $display("[TB] FAIL seq_pc[%0d] actual=%h required=%h", i, ipc_a, 4 * i); end
      nChecks++; if (itgt_a !== 64'(4 * i + 4)) begin nFails++; $display("[TB] FAIL seq_tgt[%0d] actual=%h required=%h", i, itgt_a, 4 * i + 4); end
      nChecks++; if (insn_a !== 32'h1000_0000 + i) begin nFails++; $display("[TB] FAIL seq_insn[%0d] actual=%h", i, insn_a); end
      nChecks++; if (pred_a !== 1'b0) begin nFails++; $display("[TB] FAIL seq_pred[%0d] actual=%0b required=0", i, pred_a); end
      nextCycle();
    end
  endtask

  // Taken prediction at PC=10 with target 40.
  task automatic test_predicted();
    bp_taken = 1'b1; bp_tgt = 64'h40; ic_insn = 32'hB000_0001;
    sampleEdge();
    nChecks++; if (en_a !== 1'b1) begin nFails++; $display("[TB] FAIL pred_en actual=%0b required=1", en_a); end
    nChecks++; if (ipc_a !== 64'h10) begin nFails++; $display("[TB] FAIL pred_pc actual=%h required=10", ipc_a); end
    nChecks++; if (itgt_a !== 64'h40) begin nFails++; $display("[TB] FAIL pred_tgt actual=%h required=40", itgt_a); end
    nChecks++; if (pred_a !== 1'b1) begin nFails++; $display("[TB] FAIL pred_bit actual=%0b required=1", pred_a); end
    nextCycle();
    bp_taken = 1'b0; ic_valid = 1'b0;
    sampleEdge();
    nChecks++; if (addr_a !== 64'h40) begin nFails++; $display("[TB] FAIL pred_next_addr actual=%h required=40", addr_a); end
  endtask

  // The response for PC=40 arrives while the buffer is full.
  task automatic test_backpressure();
    nextCycle();
    ic_valid = 1'b1; ifb_full = 1'b1; ic_insn = 32'hC0DE_0040;
    sampleEdge();
    nChecks++; if (en_a !== 1'b0) begin nFails++; $display("[TB] FAIL bp_full_no_push actual=%0b required=0", en_a); end
    nextCycle();
    ic_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sampleEdge();
      nChecks++; if (st_a !== 2'd1) begin nFails++; $display("[TB] FAIL bp_hold_state[%0d] actual=%0d required=1", i, st_a); end
      nChecks++; if (req_a !== 1'b0) begin nFails++; $display("[TB] FAIL bp_hold_req[%0d] actual=%0b required=0", i, req_a); end
      nChecks++; if (en_a !== 1'b0) begin nFails++; $display("[TB] FAIL bp_hold_en[%0d] actual=%0b required=0", i, en_a); end
      nextCycle();
    end
    ifb_full = 1'b0;
    sampleEdge();
    nChecks++; if (en_a !== 1'b1) begin nFails++; $display("[TB] FAIL bp_release_en actual=%0b required=1", en_a); end
    nChecks++; if (ipc_a !== 64'h40) begin nFails++; $display("[TB] FAIL bp_release_pc actual=%h required=40", ipc_a); end
    nChecks++; if (itgt_a !== 64'h44) begin nFails++; $display("[TB] FAIL bp_release_tgt actual=%h required=44", itgt_a); end
    nChecks++; if (insn_a !== 32'hC0DE_0040) begin nFails++; $display("[TB] FAIL bp_release_insn actual=%h required=c0de0040", insn_a); end
    nextCycle();
    sampleEdge();
    nChecks++; if (en_a !== 1'b0) begin nFails++; $display("[TB] FAIL bp_single_push actual=%0b required=0", en_a); end
    nChecks++; if (st_a !== 2'd0) begin nFails++; $display("[TB] FAIL bp_back_fetch actual=%0d required=0", st_a); end
    nChecks++; if (addr_a !== 64'h44) begin nFails++; $display("[TB] FAIL bp_next_addr actual=%h required=44", addr_a); end
    nextCycle();
    ic_valid = 1'b1;
    nextCycle();
    ic_valid = 1'b0;
  endtask

  // Flush to 100 while the request for PC=48 is outstanding.
  task automatic test_flush_inflight();
    flush_en = 1'b1; flush_tgt = 64'h100;
    sampleEdge();
    nChecks++; if (addr_a !== 64'h48) begin nFails++; $display("[TB] FAIL fi_pre_addr actual=%h required=48", addr_a); end
    nextCycle();
    flush_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sampleEdge();
      nChecks++; if (st_a !== 2'd2) begin nFails++; $display("[TB] FAIL fi_state[%0d] actual=%0d required=2", i, st_a); end
      nChecks++; if (addr_a !== 64'h48) begin nFails++; $display("[TB] FAIL fi_addr[%0d] actual=%h required=48", i, addr_a); end
      nChecks++; if (req_a !== 1'b1) begin nFails++; $display("[TB] FAIL fi_req[%0d] actual=%0b required=1", i, req_a); end
      nChecks++; if (fpc_a !== 64'h100) begin nFails++; $display("[TB] FAIL fi_pc[%0d] actual=%h required=100", i, fpc_a); end
      nextCycle();
    end
    ic_valid = 1'b1;
    sampleEdge();
    nChecks++; if (en_a !== 1'b0) begin nFails++; $display("[TB] FAIL fi_drop actual=%0b required=0", en_a); end
    nextCycle();
    ic_valid = 1'b0;
    sampleEdge();
    nChecks++; if (st_a !== 2'd0) begin nFails++; $display("[TB] FAIL fi_back_fetch actual=%0d required=0", st_a); end
    nChecks++; if (addr_a !== 64'h100) begin nFails++; $display("[TB] FAIL fi_next_addr actual=%h required=100", addr_a); end
    nextCycle();
  endtask

  // A flush that coincides with a valid response, then a flush during HOLD.
  task automatic test_flush_coincident();
    ic_valid = 1'b1; flush_en = 1'b1; flush_tgt = 64'h200;
    sampleEdge();
    nChecks++; if (en_a !== 1'b0) begin nFails++; $display("[TB] FAIL fv_no_push actual=%0b required=0", en_a); end
    nextCycle();
    flush_en = 1'b0; ifb_full = 1'b1; ic_insn = 32'hBAD0_0200;
    sampleEdge();
    nChecks++; if (st_a !== 2'd0) begin nFails++; $display("[TB] FAIL fv_state actual=%0d required=0", st_a); end
    nChecks++; if (addr_a !== 64'h200) begin nFails++; $display("[TB] FAIL fv_addr actual=%h required=200", addr_a); end
    nextCycle();
    ic_valid = 1'b0; ifb_full = 1'b0; flush_en = 1'b1; flush_tgt = 64'h300;
    sampleEdge();
    nChecks++; if (st_a !== 2'd1) begin nFails++; $display("[TB] FAIL fh_in_hold actual=%0d required=1", st_a); end
    nChecks++; if (en_a !== 1'b0) begin nFails++; $display("[TB] FAIL fh_no_push actual=%0b required=0", en_a); end
    nextCycle();
    flush_en = 1'b0;
    sampleEdge();
    nChecks++; if (st_a !== 2'd0) begin nFails++; $display("[TB] FAIL fh_state actual=%0d required=0", st_a); end
    nChecks++; if (addr_a !== 64'h300) begin nFails++; $display("[TB] FAIL fh_addr actual=%h required=300", addr_a); end
    nChecks++; if (en_a !== 1'b0) begin nFails++; $display("[TB] FAIL fh_hold_dropped actual=%0b required=0", en_a); end
    nextCycle();
    ic_valid = 1'b1; ic_insn = 32'h0000_0300;
    sampleEdge();
    nChecks++; if (en_a !== 1'b1) begin nFails++; $display("[TB] FAIL fh_resume_en actual=%0b required=1", en_a); end
    nChecks++; if (ipc_a !== 64'h300) begin nFails++; $display("[TB] FAIL fh_resume_pc actual=%h required=300", ipc_a); end
    nChecks++; if (itgt_a !== 64'h304) begin nFails++; $display("[TB] FAIL fh_resume_tgt actual=%h required=304", itgt_a); end
    nextCycle();
    ic_valid = 1'b0;
  endtask

  // The instance reset at FFFF_FFFF_FFFF_FFFC wraps its next PC to 0.
  task automatic test_pc_wrap();
    rst = 1'b1; ic_valid = 1'b0; flush_en = 1'b0; ifb_full = 1'b0; bp_taken = 1'b0;
    nextCycle();
    rst = 1'b0; ic_valid = 1'b1; ic_insn = 32'hFFFF_0001;
    sampleEdge();
    nChecks++; if (addr_b !== 64'hFFFF_FFFF_FFFF_FFFC) begin nFails++; $display("[TB] FAIL wrap_addr actual=%h required=fffffffffffffffc", addr_b); end
    nChecks++; if (en_b !== 1'b1) begin nFails++; $display("[TB] FAIL wrap_en actual=%0b required=1", en_b); end
    nChecks++; if (ipc_b !== 64'hFFFF_FFFF_FFFF_FFFC) begin nFails++; $display("[TB] FAIL wrap_pc actual=%h required=fffffffffffffffc", ipc_b); end
    nChecks++; if (itgt_b !== 64'h0) begin nFails++; $display("[TB] FAIL wrap_tgt actual=%h required=0", itgt_b); end
    nextCycle();
    ic_valid = 1'b0;
    sampleEdge();
    nChecks++; if (addr_b !== 64'h0) begin nFails++; $display("[TB] FAIL wrap_next_addr actual=%h required=0", addr_b); end
    nextCycle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_predicted();
    test_backpressure();
    test_flush_inflight();
    test_flush_coincident();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
